// File: rtl/sifh_pkg.sv
// Shared types and defaults for the SiFH acquisition front end.
// Values mirror parametersSiFH.vh so all blocks agree on widths.
package sifh_pkg;

    localparam int NP         = 10;
    localparam int PIXEL_NUM  = 6;
    localparam int ACQ_NUM    = 4;
    localparam int GAP_CYCLES = 4;

    localparam logic [NP-1:0] NO_HIT_CODE = {NP{1'b1}};

    typedef logic [NP-1:0] ts_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CAP,
        SHIFT,
        GAP,
        DONE
    } seq_state_e;

endpackage

// File: rtl/tdc_snapshot_reg.sv
// Pixel-parallel TDC capture register with an indexed read port.
// The read port already applies no-hit substitution and the reserved-code clamp.
module tdc_snapshot_reg #(
    parameter int              NP          = 10,
    parameter int              PIXEL_NUM   = 6,
    parameter int              IDX_W       = 3,
    parameter logic [NP-1:0]   NO_HIT_CODE = {NP{1'b1}}
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    load,
    input  logic [PIXEL_NUM*NP-1:0] cap_data,
    input  logic [PIXEL_NUM-1:0]    cap_hit,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [NP-1:0]           rd_data
);

    logic [PIXEL_NUM-1:0][NP-1:0] ts_q;
    logic [PIXEL_NUM-1:0]         hit_q;
    logic [PIXEL_NUM-1:0][NP-1:0] word;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            ts_q  <= '0;
            hit_q <= '0;
        end else if (load) begin
            ts_q  <= cap_data;
            hit_q <= cap_hit;
        end
    end

    // A real hit must never alias the no-hit code downstream, so it is pulled one below.
    for (genvar p = 0; p < PIXEL_NUM; p++) begin : g_pix
        assign word[p] = !hit_q[p]                ? NO_HIT_CODE :
                         (ts_q[p] == NO_HIT_CODE) ? NO_HIT_CODE - NP'(1) :
                                                    ts_q[p];
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < PIXEL_NUM; i++) begin
            if (rd_idx == IDX_W'(i)) rd_data = word[i];
        end
    end

endmodule

// File: rtl/tdc_frame_sequencer.sv
// Captures one TDC snapshot per laser shot and streams it pixel by pixel to the
// histogram builder, sequencing ACQ_NUM acquisitions per frame with idle gaps.
module tdc_frame_sequencer
    import sifh_pkg::*;
#(
    parameter int            NP          = sifh_pkg::NP,
    parameter int            PIXEL_NUM   = sifh_pkg::PIXEL_NUM,
    parameter int            ACQ_NUM     = sifh_pkg::ACQ_NUM,
    parameter int            GAP_CYCLES  = sifh_pkg::GAP_CYCLES,
    parameter logic [NP-1:0] NO_HIT_CODE = {NP{1'b1}},
    localparam int           ACQ_W       = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    frameStart,
    input  logic                    capValid,
    output logic                    capReady,
    input  logic [PIXEL_NUM*NP-1:0] capData,
    input  logic [PIXEL_NUM-1:0]    capHit,
    output logic                    wrEn,
    output logic [NP-1:0]           data,
    output logic [ACQ_W-1:0]        acqIdx,
    output logic                    busy,
    output logic                    frameDone,
    output logic                    overflow
);

    localparam int PIX_W = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    seq_state_e       state_q, state_d;
    logic [PIX_W-1:0] pix_q;
    logic [GAP_W-1:0] gap_q;
    logic [ACQ_W-1:0] acq_q;
    logic             last_pix, last_gap, last_acq;
    logic             load, stream;
    logic [NP-1:0]    rd_word;

    assign last_pix = (pix_q == PIX_W'(PIXEL_NUM - 1));
    assign last_gap = (gap_q == GAP_W'(GAP_CYCLES - 1));
    assign last_acq = (acq_q == ACQ_W'(ACQ_NUM - 1));

    assign capReady = (state_q == WAIT_CAP);
    // A restart in the same cycle as a capture takes priority; the shot is simply lost.
    assign load     = capReady && capValid && !frameStart;
    assign stream   = (state_q == SHIFT) && !frameStart;
    assign acqIdx   = acq_q;

    tdc_snapshot_reg #(
        .NP          (NP),
        .PIXEL_NUM   (PIXEL_NUM),
        .IDX_W       (PIX_W),
        .NO_HIT_CODE (NO_HIT_CODE)
    ) u_snap (
        .clk      (clk),
        .res      (res),
        .load     (load),
        .cap_data (capData),
        .cap_hit  (capHit),
        .rd_idx   (pix_q),
        .rd_data  (rd_word)
    );

    always_comb begin
        state_d = state_q;
        if (frameStart) begin
            state_d = WAIT_CAP;
        end else begin
            case (state_q)
                IDLE:     state_d = IDLE;
                WAIT_CAP: if (capValid) state_d = SHIFT;
                SHIFT:    if (last_pix) state_d = last_acq ? DONE : GAP;
                GAP:      if (last_gap) state_d = WAIT_CAP;
                DONE:     state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q   <= IDLE;
            pix_q     <= '0;
            gap_q     <= '0;
            acq_q     <= '0;
            wrEn      <= 1'b0;
            data      <= '0;
            busy      <= 1'b0;
            frameDone <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_d == SHIFT && state_q != SHIFT)  pix_q <= '0;
            else if (state_q == SHIFT && !last_pix)    pix_q <= pix_q + 1'b1;

            if (state_d == GAP && state_q != GAP)      gap_q <= '0;
            else if (state_q == GAP && !last_gap)      gap_q <= gap_q + 1'b1;

            if (frameStart)                                  acq_q <= '0;
            else if (state_q == SHIFT && state_d == GAP)     acq_q <= acq_q + 1'b1;

            // Stream stage sits one register behind the state, giving the one-edge handshake latency.
            wrEn      <= stream;
            data      <= stream ? rd_word : '0;
            busy      <= (state_d != IDLE);
            frameDone <= (state_q == DONE) && !frameStart;

            if (frameStart)
                overflow <= 1'b0;
            else if (capValid && (state_q == SHIFT || state_q == GAP || state_q == DONE))
                overflow <= 1'b1;
        end
    end

endmodule
